// File: rtl/shift_gearbox.sv
// shift_gearbox: width-converting deserialiser. Packs N = DOUT_WIDTH/DIN_WIDTH
// input chunks into one output word, with valid/ready on both sides.
//
// Ports:
//   clk, rst              clock (rising edge) and asynchronous active-high reset
//   in_valid/in_ready/din input chunk handshake
//   flush                 emit a partial word (cnt > 0) at the next opportunity
//   out_valid/out_ready   output word handshake
//   dout, out_count       assembled word and number of valid chunks in it
//   ovf, ovf_clr          sticky overflow flag and its clear
//
// Build option: define SHIFT_GEARBOX_OVF_EN to get the sticky overflow
// register; otherwise ovf is tied low and ovf_clr is ignored.
module shift_gearbox #(
   parameter int DIN_WIDTH  = 8,
   parameter int DOUT_WIDTH = 24,
   parameter bit MSB_FIRST  = 1'b1
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      in_valid,
   output logic                                      in_ready,
   input  logic [DIN_WIDTH-1:0]                      din,
   input  logic                                      flush,
   output logic                                      out_valid,
   input  logic                                      out_ready,
   output logic [DOUT_WIDTH-1:0]                     dout,
   output logic [$clog2(DOUT_WIDTH/DIN_WIDTH+1)-1:0] out_count,
   output logic                                      ovf,
   input  logic                                      ovf_clr
);

   localparam int N  = DOUT_WIDTH / DIN_WIDTH;
   localparam int CW = $clog2(N + 1);

   generate
      if ((DOUT_WIDTH % DIN_WIDTH) != 0 || N < 2) begin : g_bad_params
         $error("shift_gearbox: DOUT_WIDTH must be a multiple (>= 2x) of DIN_WIDTH");
      end
   endgenerate

   typedef enum logic {S_FILL, S_HOLD} state_t;

   state_t                r_state;
   logic [DOUT_WIDTH-1:0] r_word;
   logic [CW-1:0]         r_cnt;

   logic [DOUT_WIDTH-1:0] w_base;
   logic [DOUT_WIDTH-1:0] w_shift;
   logic [CW-1:0]         w_cnt_inc;
   logic                  w_acc;

   assign in_ready  = ~rst & ((r_state == S_FILL) | out_ready);
   assign w_acc     = in_valid & in_ready;
   assign out_valid = (r_state == S_HOLD);
   assign dout      = r_word;
   assign out_count = r_cnt;
   assign w_cnt_inc = r_cnt + CW'(1);

   // In HOLD an accept can only happen together with the output handshake,
   // so the new chunk is shifted into a cleared word.
   assign w_base = (r_state == S_HOLD) ? '0 : r_word;

   // Shifting a word that starts at zero leaves the valid chunks in the low
   // bits (MSB first) or high bits (LSB first), which is exactly the partial
   // word layout on a flush.
   generate
      if (MSB_FIRST) begin : g_msb
         assign w_shift = (w_base << DIN_WIDTH) | DOUT_WIDTH'(din);
      end else begin : g_lsb
         assign w_shift = (w_base >> DIN_WIDTH) |
                          {din, {(DOUT_WIDTH-DIN_WIDTH){1'b0}}};
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_FILL;
         r_word  <= '0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_FILL: begin
               if (w_acc) begin
                  r_word <= w_shift;
                  r_cnt  <= w_cnt_inc;
                  // cnt is at least 1 after an accept, so flush always applies.
                  if (w_cnt_inc == CW'(N) || flush) r_state <= S_HOLD;
               end else if (flush && r_cnt != '0) begin
                  r_state <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (out_ready) begin
                  r_state <= S_FILL;
                  if (in_valid) begin
                     r_word <= w_shift;
                     r_cnt  <= CW'(1);
                  end else begin
                     r_word <= '0;
                     r_cnt  <= '0;
                  end
               end
            end
            default: r_state <= S_FILL;
         endcase
      end
   end

`ifdef SHIFT_GEARBOX_OVF_EN
   logic r_ovf;

   // A chunk offered while we cannot take it is lost; set beats clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                      r_ovf <= 1'b0;
      else if (in_valid & ~in_ready) r_ovf <= 1'b1;
      else if (ovf_clr)             r_ovf <= 1'b0;
   end

   assign ovf = r_ovf;
`else
   logic w_unused_ovf_clr;
   assign w_unused_ovf_clr = ovf_clr;
   assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_shift_gearbox.sv
// Self-checking bench for shift_gearbox: one MSB-first and one LSB-first
// instance share stimulus; directed scenarios plus a randomized run against a
// chunk-queue reference model.
module tb_shift_gearbox;
   localparam int DW = 8;
   localparam int OW = 24;
   localparam int N  = OW / DW;
`ifdef SHIFT_GEARBOX_OVF_EN
   localparam bit OVF_ON = 1'b1;
`else
   localparam bit OVF_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, flush, out_ready, ovf_clr;
   logic [DW-1:0] din;

   logic          m_in_ready, m_out_valid, m_ovf;
   logic [OW-1:0] m_dout;
   logic [1:0]    m_cnt;
   logic          l_in_ready, l_out_valid, l_ovf;
   logic [OW-1:0] l_dout;
   logic [1:0]    l_cnt;

   int n_cmp = 0;
   int n_err = 0;

   logic [DW-1:0] mq[$];

   always #5 clk = ~clk;

   shift_gearbox #(.DIN_WIDTH(DW), .DOUT_WIDTH(OW), .MSB_FIRST(1'b1)) dut_msb (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready), .din(din),
      .flush(flush), .out_valid(m_out_valid), .out_ready(out_ready), .dout(m_dout),
      .out_count(m_cnt), .ovf(m_ovf), .ovf_clr(ovf_clr));

   shift_gearbox #(.DIN_WIDTH(DW), .DOUT_WIDTH(OW), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(l_in_ready), .din(din),
      .flush(flush), .out_valid(l_out_valid), .out_ready(out_ready), .dout(l_dout),
      .out_count(l_cnt), .ovf(l_ovf), .ovf_clr(ovf_clr));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Expected word from the chunks currently in mq, by positional arithmetic.
   function automatic logic [OW-1:0] pack(input bit msb);
      logic [OW-1:0] w;
      int k;
      w = '0;
      k = mq.size();
      for (int i = 0; i < k; i++)
         w = w | (OW'(mq[i]) << (DW * (msb ? (k - 1 - i) : (N - k + i))));
      return w;
   endfunction

   task automatic test_reset;
      rst = 1'b1; in_valid = 1'b1; din = 8'hA5; flush = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
      tick; tick;
      n_cmp++; if (m_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", m_out_valid); end
      n_cmp++; if (m_dout !== '0 || l_dout !== '0) begin n_err++; $display("FAIL reset_dout: got %h/%h want 0", m_dout, l_dout); end
      n_cmp++; if (m_cnt !== 2'd0) begin n_err++; $display("FAIL reset_out_count: got %0d want 0", m_cnt); end
      n_cmp++; if (m_in_ready !== 1'b0 || l_in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b/%b want 0", m_in_ready, l_in_ready); end
      n_cmp++; if (m_ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", m_ovf); end
      rst = 1'b0; in_valid = 1'b0;
      #1;
      n_cmp++; if (m_in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready: got %b want 1", m_in_ready); end
   endtask

   task automatic test_basic;
      logic [DW-1:0] b[3];
      b[0] = 8'h11; b[1] = 8'h22; b[2] = 8'h33;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; din = b[i];
         #1;
         n_cmp++; if (m_out_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid[%0d]: got %b want 0", i, m_out_valid); end
         tick;
      end
      in_valid = 1'b0;
      n_cmp++; if (m_out_valid !== 1'b1 || l_out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b/%b want 1", m_out_valid, l_out_valid); end
      n_cmp++; if (m_dout !== 24'h112233) begin n_err++; $display("FAIL basic_msb_dout: got %h want 112233", m_dout); end
      n_cmp++; if (l_dout !== 24'h332211) begin n_err++; $display("FAIL basic_lsb_dout: got %h want 332211", l_dout); end
      n_cmp++; if (m_cnt !== 2'd3 || l_cnt !== 2'd3) begin n_err++; $display("FAIL basic_count: got %0d/%0d want 3", m_cnt, l_cnt); end
      tick;
      n_cmp++; if (m_out_valid !== 1'b0) begin n_err++; $display("FAIL basic_drain: got %b want 0", m_out_valid); end
   endtask

   task automatic test_backpressure;
      logic [DW-1:0] b[3];
      b[0] = 8'hA1; b[1] = 8'hB2; b[2] = 8'hC3;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin in_valid = 1'b1; din = b[i]; tick; end
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_cmp++; if (m_in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, m_in_ready); end
         n_cmp++; if (m_dout !== 24'hA1B2C3 || m_cnt !== 2'd3 || m_out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold[%0d]: got %h/%0d/%b want a1b2c3/3/1", i, m_dout, m_cnt, m_out_valid); end
         tick;
      end
      out_ready = 1'b1; in_valid = 1'b1; din = 8'h44;
      #1;
      n_cmp++; if (m_in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %b want 1", m_in_ready); end
      tick;
      n_cmp++; if (m_out_valid !== 1'b0) begin n_err++; $display("FAIL bp_after_hs: got %b want 0", m_out_valid); end
      din = 8'h55; tick;
      din = 8'h66; tick;
      in_valid = 1'b0;
      n_cmp++; if (m_dout !== 24'h445566 || m_out_valid !== 1'b1) begin n_err++; $display("FAIL bp_next_msb: got %h/%b want 445566/1", m_dout, m_out_valid); end
      n_cmp++; if (l_dout !== 24'h665544) begin n_err++; $display("FAIL bp_next_lsb: got %h want 665544", l_dout); end
      tick;
   endtask

   task automatic test_flush;
      out_ready = 1'b1;
      in_valid = 1'b1; din = 8'hAA; tick;
      in_valid = 1'b0; flush = 1'b1; tick;
      n_cmp++; if (m_out_valid !== 1'b1 || m_dout !== 24'h0000AA || m_cnt !== 2'd1) begin n_err++; $display("FAIL flush_msb: got %b/%h/%0d want 1/0000aa/1", m_out_valid, m_dout, m_cnt); end
      n_cmp++; if (l_dout !== 24'hAA0000 || l_cnt !== 2'd1) begin n_err++; $display("FAIL flush_lsb: got %h/%0d want aa0000/1", l_dout, l_cnt); end
      tick;
      n_cmp++; if (m_out_valid !== 1'b0) begin n_err++; $display("FAIL flush_drain: got %b want 0", m_out_valid); end
      tick;
      n_cmp++; if (m_out_valid !== 1'b0 || l_out_valid !== 1'b0) begin n_err++; $display("FAIL flush_empty: got %b/%b want 0", m_out_valid, l_out_valid); end
      // accept and flush in the same cycle from empty
      in_valid = 1'b1; din = 8'h5A; tick;
      in_valid = 1'b0; flush = 1'b0;
      n_cmp++; if (m_out_valid !== 1'b1 || m_dout !== 24'h00005A || m_cnt !== 2'd1) begin n_err++; $display("FAIL flush_acc_msb: got %b/%h/%0d want 1/00005a/1", m_out_valid, m_dout, m_cnt); end
      n_cmp++; if (l_dout !== 24'h5A0000) begin n_err++; $display("FAIL flush_acc_lsb: got %h want 5a0000", l_dout); end
      tick;
      // flush on the completing chunk yields a normal full word
      in_valid = 1'b1; din = 8'h01; tick;
      din = 8'h02; tick;
      din = 8'h03; flush = 1'b1; tick;
      in_valid = 1'b0; flush = 1'b0;
      n_cmp++; if (m_dout !== 24'h010203 || m_cnt !== 2'd3) begin n_err++; $display("FAIL flush_full_msb: got %h/%0d want 010203/3", m_dout, m_cnt); end
      n_cmp++; if (l_dout !== 24'h030201) begin n_err++; $display("FAIL flush_full_lsb: got %h want 030201", l_dout); end
      tick;
   endtask

   task automatic test_reset_midword;
      out_ready = 1'b1;
      in_valid = 1'b1; din = 8'h01; tick;
      din = 8'h02; tick;
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      n_cmp++; if (m_out_valid !== 1'b0 || m_dout !== '0 || m_cnt !== 2'd0 || m_in_ready !== 1'b0) begin n_err++; $display("FAIL rst_async: got %b/%h/%0d/%b want 0/0/0/0", m_out_valid, m_dout, m_cnt, m_in_ready); end
      tick;
      rst = 1'b0;
      in_valid = 1'b1; din = 8'h07; tick;
      din = 8'h08; tick;
      din = 8'h09; tick;
      in_valid = 1'b0;
      n_cmp++; if (m_dout !== 24'h070809 || m_cnt !== 2'd3 || m_out_valid !== 1'b1) begin n_err++; $display("FAIL rst_clean_msb: got %h/%0d/%b want 070809/3/1", m_dout, m_cnt, m_out_valid); end
      n_cmp++; if (l_dout !== 24'h090807) begin n_err++; $display("FAIL rst_clean_lsb: got %h want 090807", l_dout); end
      tick;
   endtask

   task automatic test_ovf;
      ovf_clr = 1'b1; tick; ovf_clr = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin in_valid = 1'b1; din = 8'h30 + 8'(i); tick; end
      in_valid = 1'b1; din = 8'hFF; tick;
      in_valid = 1'b0;
      n_cmp++; if (m_ovf !== OVF_ON || l_ovf !== OVF_ON) begin n_err++; $display("FAIL ovf_set: got %b/%b want %b", m_ovf, l_ovf, OVF_ON); end
      n_cmp++; if (m_dout !== 24'h303132) begin n_err++; $display("FAIL ovf_din_ignored: got %h want 303132", m_dout); end
      tick; tick;
      n_cmp++; if (m_ovf !== OVF_ON) begin n_err++; $display("FAIL ovf_sticky: got %b want %b", m_ovf, OVF_ON); end
      ovf_clr = 1'b1; tick;
      n_cmp++; if (m_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b want 0", m_ovf); end
      in_valid = 1'b1; tick;
      in_valid = 1'b0;
      n_cmp++; if (m_ovf !== OVF_ON) begin n_err++; $display("FAIL ovf_set_wins: got %b want %b", m_ovf, OVF_ON); end
      tick;
      ovf_clr = 1'b0;
      n_cmp++; if (m_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clear2: got %b want 0", m_ovf); end
      out_ready = 1'b1; tick;
   endtask

   task automatic test_random;
      bit            hold;
      bit            exp_rdy;
      bit            acc;
      logic [OW-1:0] exp_m, exp_l;
      int            exp_k;
      hold = 1'b0; exp_m = '0; exp_l = '0; exp_k = 0;
      mq.delete();
      in_valid = 1'b0; flush = 1'b0;
      rst = 1'b1; tick; rst = 1'b0;
      for (int c = 0; c < 400; c++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         din       = DW'($urandom);
         flush     = ($urandom_range(0, 9) == 0);
         out_ready = ($urandom_range(0, 9) < 6);
         #1;
         exp_rdy = !hold || out_ready;
         n_cmp++; if (m_in_ready !== exp_rdy || l_in_ready !== exp_rdy) begin n_err++; $display("FAIL rnd_in_ready@%0d: got %b/%b want %b", c, m_in_ready, l_in_ready, exp_rdy); end
         n_cmp++; if (m_out_valid !== hold || l_out_valid !== hold) begin n_err++; $display("FAIL rnd_out_valid@%0d: got %b/%b want %b", c, m_out_valid, l_out_valid, hold); end
         if (hold) begin
            n_cmp++; if (m_dout !== exp_m || l_dout !== exp_l) begin n_err++; $display("FAIL rnd_dout@%0d: got %h/%h want %h/%h", c, m_dout, l_dout, exp_m, exp_l); end
            n_cmp++; if (int'(m_cnt) != exp_k || int'(l_cnt) != exp_k) begin n_err++; $display("FAIL rnd_count@%0d: got %0d/%0d want %0d", c, m_cnt, l_cnt, exp_k); end
         end
         acc = in_valid && exp_rdy;
         if (hold) begin
            if (out_ready) begin
               hold = 1'b0;
               if (acc) mq.push_back(din);
            end
         end else begin
            if (acc) mq.push_back(din);
            if (mq.size() == N || (flush && mq.size() > 0)) begin
               exp_m = pack(1'b1);
               exp_l = pack(1'b0);
               exp_k = mq.size();
               hold  = 1'b1;
               mq.delete();
            end
         end
         tick;
      end
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      tick;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset;
      test_basic;
      test_backpressure;
      test_flush;
      test_reset_midword;
      test_ovf;
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/shift_gearbox.md
Name: shift_gearbox

Overview:
- Parametrised width-converting deserialiser: packs N = DOUT_WIDTH/DIN_WIDTH input chunks into one output word.
- Input and output each use a valid/ready handshake.
- Chunk order is selectable; a flush pushes out a partial word.
- Sits between narrow byte-stream sources (JTAG/UART data registers) and wide register/bus consumers.

Parameters:
- DIN_WIDTH, 8: chunk width in bits.
- DOUT_WIDTH, 24: output word width; must be an integer multiple of DIN_WIDTH with N >= 2 (elaboration-time assertion).
- MSB_FIRST, 1: 1 = first chunk ends in the most significant position; 0 = first chunk ends in the least significant position.

Ports:
- clk, input, 1: clock; all logic on rising edge.
- rst, input, 1: reset, asynchronous, active-high.
- in_valid, input, 1: din is valid.
- in_ready, output, 1: block can accept a chunk this cycle.
- din, input, DIN_WIDTH: input chunk.
- flush, input, 1: emit the partial word at the next opportunity.
- out_valid, output, 1: dout/out_count are valid.
- out_ready, input, 1: consumer accepts dout.
- dout, output, DOUT_WIDTH: assembled word.
- out_count, output, $clog2(N+1): number of valid chunks in dout (N for a full word).
- ovf, output, 1: sticky overflow flag (see Optional Feature).
- ovf_clr, input, 1: clears ovf.

Behaviour:
- Reset values: dout = 0, out_count = 0, out_valid = 0, ovf = 0, internal cnt = 0, state = FILL. in_ready = 0 while rst is high.
- States:
  - FILL: in_ready = 1, out_valid = 0.
  - HOLD: out_valid = 1, in_ready = out_ready.
- Accept = in_valid & in_ready.
- Shift on accept:
  - MSB_FIRST = 1: word <= {word[DOUT_WIDTH-DIN_WIDTH-1:0], din}.
  - MSB_FIRST = 0: word <= {din, word[DOUT_WIDTH-1:DIN_WIDTH]}.
  - cnt <= cnt + 1.
- FILL -> HOLD when the accept brings cnt to N. out_count = N, dout = word, out_valid asserted the cycle after the last accepted chunk (latency 1 clk).
- Flush in FILL with cnt > 0 (after any same-cycle accept is applied) -> HOLD with out_count = cnt.
  - Unfilled chunk slots read 0.
  - MSB_FIRST = 1: valid chunks occupy the low cnt*DIN_WIDTH bits. MSB_FIRST = 0: valid chunks occupy the high bits.
- Flush is ignored when cnt == 0 with no accept, and ignored in HOLD. If a same-cycle accept completes the word, the result is a normal full word.
- Output handshake in HOLD (out_valid & out_ready):
  - With a simultaneous accept: word cleared, the new chunk shifted in, cnt = 1, state FILL.
  - Without: word cleared, cnt = 0, state FILL.
  - Sustains one word per N cycles with no bubble.
- Backpressure in HOLD with out_ready = 0: dout and out_count held stable, in_ready = 0, din ignored.
- cnt never exceeds N and never wraps.
- Async reset mid-word discards the partial word immediately; no output is produced for it.

Optional Feature:
- Macro: SHIFT_GEARBOX_OVF_EN.
- Defined:
  - ovf sets, registered, on any cycle with in_valid = 1 and in_ready = 0 (rst low).
  - ovf stays set until ovf_clr = 1. Set wins over a same-cycle clear.
- Undefined: ovf is tied to 0, ovf_clr is ignored, and no overflow register is synthesised.
- Ports are identical in both builds.

Test Plan:
- Defaults, MSB_FIRST = 1; send 0x11, 0x22, 0x33 back-to-back with out_ready = 1 -> one cycle later out_valid = 1, dout = 0x112233, out_count = 3.
- MSB_FIRST = 0, same stimulus -> dout = 0x332211, out_count = 3.
- Word complete, out_ready = 0 for 5 cycles -> in_ready = 0 and dout stable; then out_ready = 1 with in_valid = 1, din = 0x44 -> handshake, next word begins with cnt = 1; 0x55, 0x66 -> dout = 0x445566.
- Send 0xAA, then flush -> out_valid = 1, dout = 0x0000AA, out_count = 1; flush again with cnt = 0 -> no output.
- Accept 0x01, 0x02, assert rst for 1 cycle, then send 0x07, 0x08, 0x09 -> dout = 0x070809 with no stale data; all outputs 0 during reset.
- With SHIFT_GEARBOX_OVF_EN: hold out_ready = 0 in HOLD and pulse in_valid -> ovf = 1 and held; ovf_clr -> ovf = 0. Without the macro, same stimulus -> ovf stays 0.
